db_enb_gen: RTL and testbench



---
 rtl/db_pkg.sv | 16 +
 rtl/sync_chain.sv | 25 ++
 rtl/db_enb_gen.sv | 107 ++++++++++
 tb/tb_db_enb_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// Shared types and helpers for the debounced enable generator.
// Sizes the debounce counter and names the FSM states.
package db_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_e;

    localparam int MIN_DB_CYCLES = 2;

    function automatic int db_cnt_w(int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for a single asynchronous bit; all stages clear to 0 on reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/db_enb_gen.sv
// Synchronise + debounce a raw pin into a clean level with a one-cycle enable strobe
// on every accepted change, intended to drive a downstream enabled flop.
module db_enb_gen
    import db_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1000
) (
    input  logic cclk,
    input  logic rst_n,
    input  logic din,
    output logic d_o,
    output logic enb_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int CNT_W = db_cnt_w(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < MIN_DB_CYCLES) begin : g_bad_db
        $error("db_enb_gen: DB_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("db_enb_gen: SYNC_STAGES must be in 2..4");
    end

    logic din_s;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (cclk),
        .rst_n (rst_n),
        .d     (din),
        .q     (din_s)
    );

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             d_q,     d_d;
    logic             enb_q,   enb_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE: begin
                if (din_s != d_q) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                if (din_s == d_q) begin
                    // candidate fell back before the window filled: drop it silently
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    d_d     = din_s;
                    rise_d  = din_s;
                    fall_d  = ~din_s;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
        enb_d = rise_d | fall_d;
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            enb_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            enb_q   <= enb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign d_o    = d_q;
    assign enb_o  = enb_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = (state_q == COUNT);

endmodule

// File: tb/tb_db_enb_gen.sv
// Bench for db_enb_gen: vector table, directed corner sequences and a randomized
// run against a sliding-window reference model; includes a downstream enabled flop.
module tb_db_enb_gen;

    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic cclk = 1'b0;
    logic rst_n;
    logic din;
    logic d_o, enb_o, rise_o, fall_o, busy_o;
    logic dq;
    logic [5:0] outs;

    always #5 cclk = ~cclk;

    db_enb_gen #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
        .cclk   (cclk),
        .rst_n  (rst_n),
        .din    (din),
        .d_o    (d_o),
        .enb_o  (enb_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .busy_o (busy_o)
    );

    // downstream enabled flop fed by the generator
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n)     dq <= 1'b0;
        else if (enb_o) dq <= d_o;
    end

    assign outs = {d_o, enb_o, rise_o, fall_o, busy_o, dq};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chkv(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got d,enb,rise,fall,busy,q=%b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: din seen by the decision logic is din delayed SYNC edges; a level
    // is accepted once the last DB seen samples all differ from the current level.
    logic hist[$];
    logic seen[$];
    logic m_d, m_enb, m_rise, m_fall, m_busy, m_q;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        seen.delete();
        {m_d, m_enb, m_rise, m_fall, m_busy, m_q} = '0;
    endtask

    task automatic model_edge();
        logic s;
        bit   acc;
        if (m_enb) m_q = m_d;
        hist.push_back(din);
        s = hist.pop_front();
        seen.push_back(s);
        if (seen.size() > DB) void'(seen.pop_front());
        acc = (seen.size() == DB);
        foreach (seen[i]) if (seen[i] == m_d) acc = 1'b0;
        m_busy = !acc && (s != m_d);
        m_enb  = acc;
        m_rise = acc && !m_d;
        m_fall = acc && m_d;
        if (acc) begin
            m_d = ~m_d;
            seen.delete();
        end
    endtask

    task automatic step(input logic v);
        din = v;
        @(posedge cclk);
        model_edge();
        @(negedge cclk);
    endtask

    task automatic do_reset(input logic v);
        din   = v;
        rst_n = 1'b0;
        repeat (2) @(negedge cclk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       din;
        logic [5:0] exp;   // {d, enb, rise, fall, busy, q}
    } vec_t;

    vec_t tbl[20];

    initial begin
        int npulse;

        // clean rise, clean fall (with downstream flop), then a DB-1 glitch
        tbl[0]  = '{1'b1, 6'b000000};
        tbl[1]  = '{1'b1, 6'b000000};
        tbl[2]  = '{1'b1, 6'b000010};
        tbl[3]  = '{1'b1, 6'b000010};
        tbl[4]  = '{1'b1, 6'b000010};
        tbl[5]  = '{1'b1, 6'b111000};
        tbl[6]  = '{1'b1, 6'b100001};
        tbl[7]  = '{1'b0, 6'b100001};
        tbl[8]  = '{1'b0, 6'b100001};
        tbl[9]  = '{1'b0, 6'b100011};
        tbl[10] = '{1'b0, 6'b100011};
        tbl[11] = '{1'b0, 6'b100011};
        tbl[12] = '{1'b0, 6'b010101};
        tbl[13] = '{1'b1, 6'b000000};
        tbl[14] = '{1'b1, 6'b000000};
        tbl[15] = '{1'b1, 6'b000010};
        tbl[16] = '{1'b0, 6'b000010};
        tbl[17] = '{1'b0, 6'b000010};
        tbl[18] = '{1'b0, 6'b000000};
        tbl[19] = '{1'b0, 6'b000000};

        // 1: reset with din=1, outputs held at 0, then rise 6 edges after release
        din   = 1'b1;
        rst_n = 1'b0;
        #1 chkv("reset_immediate", outs, 6'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge cclk);
            chkv("reset_hold", outs, 6'b0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            chkv($sformatf("reset_release_e%0d", i + 1), outs,
                 {i >= 5, i == 5, i == 5, 1'b0, i >= 2 && i <= 4, i >= 6});
        end

        // 2/3/6: table of rise, fall with attached flop, and glitch rejection
        do_reset(1'b0);
        repeat (4) step(1'b0);
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].din);
            chkv($sformatf("table_%0d", i), outs, tbl[i].exp);
        end

        // 4: bounce restarts the count; one strobe, 6 edges after the final 0->1
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            step(i == 1 ? 1'b0 : 1'b1);
            if (enb_o) npulse++;
            chk($sformatf("bounce_d_%0d", i), int'(d_o), int'(i >= 7));
            if (i == 7) chk("bounce_enb_at_accept", int'(enb_o), 1);
        end
        chk("bounce_pulse_count", npulse, 1);

        // 5: reset in the middle of a count aborts it with no strobe
        do_reset(1'b0);
        repeat (3) step(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1);
        chk("midreset_busy_before", int'(busy_o), 1);
        #2 rst_n = 1'b0;
        #1 chkv("midreset_immediate", outs, 6'b0);
        din = 1'b0;
        @(negedge cclk);
        rst_n = 1'b1;
        model_reset();
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            if (enb_o) npulse++;
            chk("midreset_d_low", int'(d_o), 0);
        end
        chk("midreset_no_strobe", npulse, 0);

        // randomized bouncy input against the reference model
        do_reset(1'b0);
        for (int r = 0; r < 400; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * DB + 2);
            for (int k = 0; k < len; k++) begin
                step(lvl);
                chkv($sformatf("rand_%0d_%0d", r, k), outs,
                     {m_d, m_enb, m_rise, m_fall, m_busy, m_q});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
